// File: rtl/fichero_reg_multi.sv
// fichero_reg_multi: parametrised register file with two write ports and
// three registered read ports (one cycle of read latency), plus a sticky
// per-register dirty mask.
//
// Build option: define FICHERO_REG_BYPASS_EN to forward same-cycle write
// data into the read registers. Without it, a read of an address being
// written returns the old contents, and the new value appears one edge later.
//
// Write collision (both ports, same address): port 1 wins.
// ZERO_REG=1: register 0 ignores writes, never becomes dirty and reads 0.
module fichero_reg_multi #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w,
    input  logic [ADDR_W-1:0]        sw,
    input  logic [WIDTH-1:0]         c_in,
    input  logic                     w2,
    input  logic [ADDR_W-1:0]        sw2,
    input  logic [WIDTH-1:0]         c2_in,
    input  logic [ADDR_W-1:0]        sa,
    input  logic [ADDR_W-1:0]        sb,
    input  logic [ADDR_W-1:0]        sc,
    output logic [WIDTH-1:0]         a_out,
    output logic [WIDTH-1:0]         b_out,
    output logic [WIDTH-1:0]         d_out,
    output logic [(1<<ADDR_W)-1:0]   dirty
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] dirty_q, dirty_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Effective write enables: port 2 yields to port 1 on the same address,
    // and neither port may touch register 0 when it is hardwired.
    logic we1, we2;

    // Qualify the raw write enables.
    always_comb begin
        we1 = w;
        we2 = w2;
        if (w && w2 && (sw == sw2)) begin
            we2 = 1'b0;
        end
        if (ZERO_EN && (sw == '0)) begin
            we1 = 1'b0;
        end
        if (ZERO_EN && (sw2 == '0)) begin
            we2 = 1'b0;
        end
    end

    // Next contents of the array and dirty mask from the qualified writes.
    always_comb begin
        mem_d   = mem_q;
        dirty_d = dirty_q;
        if (we2) begin
            mem_d[sw2]   = c2_in;
            dirty_d[sw2] = 1'b1;
        end
        if (we1) begin
            mem_d[sw]   = c_in;
            dirty_d[sw] = 1'b1;
        end
    end

    // Value each read register loads at the next edge.
    always_comb begin
        a_d = mem_q[sa];
        b_d = mem_q[sb];
        d_d = mem_q[sc];
`ifdef FICHERO_REG_BYPASS_EN
        // Forward write data; port 1 checked last so it takes priority.
        if (we2 && (sw2 == sa)) a_d = c2_in;
        if (we2 && (sw2 == sb)) b_d = c2_in;
        if (we2 && (sw2 == sc)) d_d = c2_in;
        if (we1 && (sw == sa))  a_d = c_in;
        if (we1 && (sw == sb))  b_d = c_in;
        if (we1 && (sw == sc))  d_d = c_in;
`endif
        // Register 0 reads as zero when hardwired, whatever the array holds.
        if (ZERO_EN && (sa == '0)) a_d = '0;
        if (ZERO_EN && (sb == '0)) b_d = '0;
        if (ZERO_EN && (sc == '0)) d_d = '0;
    end

    // State update; reset clears everything and overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dirty_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
        end else begin
            mem_q   <= mem_d;
            dirty_q <= dirty_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign d_out = d_q;
    assign dirty = dirty_q;

endmodule

// File: tb/tb_fichero_reg_multi.sv
// Directed bench for fichero_reg_multi. Two instances share the stimulus:
// dut (ZERO_REG=0) and dut_z (ZERO_REG=1). Expected values follow the
// FICHERO_REG_BYPASS_EN setting of the build.
module tb_fichero_reg_multi;

    logic       clk;
    logic       reset;
    logic       w, w2;
    logic [2:0] sw, sw2, sa, sb, sc;
    logic [7:0] c_in, c2_in;
    logic [7:0] a_out, b_out, d_out;
    logic [7:0] dirty;
    logic [7:0] za_out, zb_out, zd_out;
    logic [7:0] zdirty;

    int errors = 0;
    int checks = 0;

`ifdef FICHERO_REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    fichero_reg_multi #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset),
        .w(w), .sw(sw), .c_in(c_in),
        .w2(w2), .sw2(sw2), .c2_in(c2_in),
        .sa(sa), .sb(sb), .sc(sc),
        .a_out(a_out), .b_out(b_out), .d_out(d_out),
        .dirty(dirty)
    );

    fichero_reg_multi #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset),
        .w(w), .sw(sw), .c_in(c_in),
        .w2(w2), .sw2(sw2), .c2_in(c2_in),
        .sa(sa), .sb(sb), .sc(sc),
        .a_out(za_out), .b_out(zb_out), .d_out(zd_out),
        .dirty(zdirty)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ed);
        chk({tag, ".a"}, {24'd0, a_out}, {24'd0, ea});
        chk({tag, ".b"}, {24'd0, b_out}, {24'd0, eb});
        chk({tag, ".d"}, {24'd0, d_out}, {24'd0, ed});
    endtask

    initial begin
        logic [7:0] exp_dirty;
        logic [7:0] v;

        reset = 1'b1;
        w = 1'b0; sw = '0; c_in = '0;
        w2 = 1'b0; sw2 = '0; c2_in = '0;
        sa = '0; sb = '0; sc = '0;

        // 1. Two reset cycles, then every address reads 0 and nothing is dirty
        tick();
        tick();
        chk3("rst", 8'h00, 8'h00, 8'h00);
        chk("rst.dirty", {24'd0, dirty}, 32'h0);
        chk("rst.zdirty", {24'd0, zdirty}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa = 3'(i); sb = 3'(7 - i); sc = 3'(i);
            tick();
            chk3("rd0", 8'h00, 8'h00, 8'h00);
            chk("rd0.dirty", {24'd0, dirty}, 32'h0);
        end

        // 2. Write i+1 to each address while reading it back on all ports
        exp_dirty = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w = 1'b1; sw = 3'(i); c_in = 8'(i + 1);
            sa = 3'(i); sb = 3'(i); sc = 3'(i);
            tick();
            exp_dirty[i] = 1'b1;
            v = BYP ? 8'(i + 1) : 8'h00;
            chk3("wr_edge", v, v, v);
            chk("wr_edge.dirty", {24'd0, dirty}, {24'd0, exp_dirty});
            w = 1'b0;
            tick();
            chk3("wr_next", 8'(i + 1), 8'(i + 1), 8'(i + 1));
            chk("wr_next.dirty", {24'd0, dirty}, {24'd0, exp_dirty});
        end

        // 3a. Collision on address 5: port 1 wins
        w = 1'b1; sw = 3'd5; c_in = 8'hAA;
        w2 = 1'b1; sw2 = 3'd5; c2_in = 8'h55;
        sa = 3'd5; sb = 3'd5; sc = 3'd5;
        tick();
        v = BYP ? 8'hAA : 8'h06;
        chk3("coll_edge", v, v, v);
        w = 1'b0; w2 = 1'b0;
        tick();
        chk3("coll_next", 8'hAA, 8'hAA, 8'hAA);
        chk("coll.dirty", {24'd0, dirty}, 32'hFF);

        // 3b. Distinct addresses 5 and 6 commit together
        w = 1'b1; sw = 3'd5; c_in = 8'hAA;
        w2 = 1'b1; sw2 = 3'd6; c2_in = 8'h55;
        sa = 3'd5; sb = 3'd6; sc = 3'd6;
        tick();
        v = BYP ? 8'h55 : 8'h07;
        chk3("dual_edge", 8'hAA, v, v);
        w = 1'b0; w2 = 1'b0;
        tick();
        chk3("dual_next", 8'hAA, 8'h55, 8'h55);

        // 4. Three simultaneous reads with aliasing
        sa = 3'd4; sb = 3'd3; sc = 3'd4;
        tick();
        chk3("multi_rd", 8'h05, 8'h04, 8'h05);

        // 5. Register 0 hardwired on dut_z; dut stores the value normally
        w = 1'b1; sw = 3'd0; c_in = 8'hFF;
        sa = 3'd0; sb = 3'd0; sc = 3'd0;
        tick();
        chk("z0_edge.a", {24'd0, za_out}, 32'h0);
        v = BYP ? 8'hFF : 8'h01;
        chk("n0_edge.a", {24'd0, a_out}, {24'd0, v});
        w = 1'b0;
        tick();
        chk("z0_next.a", {24'd0, za_out}, 32'h0);
        chk("z0_next.d", {24'd0, zd_out}, 32'h0);
        chk("z0.dirty", {24'd0, zdirty}, 32'hFE);
        chk("n0_next.a", {24'd0, a_out}, 32'hFF);

        // 5b. Address 1 behaves normally on dut_z
        w = 1'b1; sw = 3'd1; c_in = 8'h3C;
        sa = 3'd1; sb = 3'd0; sc = 3'd1;
        tick();
        v = BYP ? 8'h3C : 8'h02;
        chk("z1_edge.a", {24'd0, za_out}, {24'd0, v});
        w = 1'b0;
        tick();
        chk("z1_next.a", {24'd0, za_out}, 32'h3C);
        chk("z1_next.b", {24'd0, zb_out}, 32'h0);

        // 5c. Collision targeting address 0 changes nothing on dut_z
        w = 1'b1; sw = 3'd0; c_in = 8'h11;
        w2 = 1'b1; sw2 = 3'd0; c2_in = 8'h22;
        sa = 3'd0; sb = 3'd0; sc = 3'd0;
        tick();
        chk("zc_edge.a", {24'd0, za_out}, 32'h0);
        w = 1'b0; w2 = 1'b0;
        tick();
        chk("zc_next.a", {24'd0, za_out}, 32'h0);
        chk("zc.dirty", {24'd0, zdirty}, 32'hFE);
        chk("nc_next.a", {24'd0, a_out}, 32'h11);

        // 6. Reset wins over a simultaneous write
        reset = 1'b1;
        w = 1'b1; sw = 3'd2; c_in = 8'h77;
        sa = 3'd2; sb = 3'd5; sc = 3'd1;
        tick();
        chk3("rstw_edge", 8'h00, 8'h00, 8'h00);
        chk("rstw.dirty", {24'd0, dirty}, 32'h0);
        chk("rstw.zdirty", {24'd0, zdirty}, 32'h0);
        reset = 1'b0; w = 1'b0;
        tick();
        chk3("rstw_next", 8'h00, 8'h00, 8'h00);
        chk("rstw_next.dirty", {24'd0, dirty}, 32'h0);
        chk("rstw_next.za", {24'd0, za_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
